// File: rtl/cpu_defs.sv
// Shared CPU definitions: mul/div op encodings and mul/div engine state codes,
// used by the decoder, the HI/LO write-back and the mul/div unit.
package cpu_defs;

  localparam int MD_XLEN = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [2:0] {
    MD_ST_IDLE,
    MD_ST_MUL,
    MD_ST_DIV,
    MD_ST_FIX,
    MD_ST_DONE
  } md_state_e;

  function automatic logic md_is_div(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // Two's-complement magnitude; 0x80000000 maps to itself, which is the
  // correct unsigned magnitude.
  function automatic logic [MD_XLEN-1:0] md_abs(input logic [MD_XLEN-1:0] v);
    return v[MD_XLEN-1] ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/muldiv_unit_div_step.sv
// One combinational restoring-divide step on the {rem,quot} pair.
module div_step
  import cpu_defs::*;
#(
  parameter int W = MD_XLEN
) (
  input  logic [W-1:0] rem_i,
  input  logic [W-1:0] quot_i,
  input  logic [W-1:0] divisor_i,
  output logic [W-1:0] rem_o,
  output logic [W-1:0] quot_o
);

  logic [W:0]   rem_sh;
  logic [W-1:0] quot_sh;
  logic [W:0]   diff;
  logic         fits;

  // The shifted remainder keeps its carry bit: with an unsigned divisor near
  // 2^32 it can exceed 32 bits before the subtract.
  assign {rem_sh, quot_sh} = {1'b0, rem_i, quot_i} << 1;
  assign diff              = rem_sh - {1'b0, divisor_i};
  assign fits              = (rem_sh >= {1'b0, divisor_i});

  assign rem_o  = fits ? diff[W-1:0] : rem_sh[W-1:0];
  assign quot_o = {quot_sh[W-1:1], fits};

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU engine for the EX stage; drives the
// stall/done handshake seen by the hazard controller and holds HI/LO.
module muldiv_unit
  import cpu_defs::*;
#(
  parameter int DIV_ITERS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  input  logic        ex_hold,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CNT_W = $clog2(DIV_ITERS + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIV_ITERS - 1);

  md_state_e        state_q, state_d;
  md_op_e           op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rem_q, rem_d;
  logic [31:0]      quot_q, quot_d;
  logic [31:0]      dvsr_q, dvsr_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  md_op_e             op_in;
  logic               signed_div;
  logic signed [32:0] mul_a, mul_b;
  logic signed [63:0] prod;
  logic [31:0]        step_rem, step_quot;

  assign op_in      = md_op_e'(op);
  assign signed_div = (op_in == MD_DIV);

  // quot_q/dvsr_q double as the multiplier operand latch. The low 64 bits of
  // the 33x33 signed product are all that is kept, so a 64-bit multiply of the
  // extended operands gives the same result.
  assign mul_a = {(op_q == MD_MULT) & quot_q[31], quot_q};
  assign mul_b = {(op_q == MD_MULT) & dvsr_q[31], dvsr_q};
  assign prod  = 64'(mul_a) * 64'(mul_b);

  div_step #(.W(32)) u_div_step (
    .rem_i     (rem_q),
    .quot_i    (quot_q),
    .divisor_i (dvsr_q),
    .rem_o     (step_rem),
    .quot_o    (step_quot)
  );

  // NOTE: every signal written here gets its hold value first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quot_d  = quot_q;
    dvsr_d  = dvsr_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    if (flush) begin
      state_d = MD_ST_IDLE;
    end else begin
      unique case (state_q)
        MD_ST_IDLE: begin
          if (start) begin
            op_d  = op_in;
            cnt_d = '0;
            if (md_is_div(op_in)) begin
              rem_d  = '0;
              quot_d = signed_div ? md_abs(a) : a;
              dvsr_d = signed_div ? md_abs(b) : b;
              qneg_d = signed_div & (a[31] ^ b[31]);
              rneg_d = signed_div & a[31];
              if (b == '0) begin
                hi_d    = a;
                lo_d    = '1;
                state_d = MD_ST_DONE;
              end else begin
                state_d = MD_ST_DIV;
              end
            end else begin
              quot_d  = a;
              dvsr_d  = b;
              state_d = MD_ST_MUL;
            end
          end
        end
        MD_ST_MUL: begin
          {hi_d, lo_d} = prod;
          state_d      = MD_ST_DONE;
        end
        MD_ST_DIV: begin
          rem_d  = step_rem;
          quot_d = step_quot;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == LAST_STEP) state_d = MD_ST_FIX;
        end
        MD_ST_FIX: begin
          hi_d    = rneg_q ? (~rem_q + 1'b1) : rem_q;
          lo_d    = qneg_q ? (~quot_q + 1'b1) : quot_q;
          state_d = MD_ST_DONE;
        end
        MD_ST_DONE: begin
          // Holding here while EX is frozen keeps the same instruction from
          // being accepted a second time.
          if (!ex_hold) state_d = MD_ST_IDLE;
        end
        default: state_d = MD_ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MD_ST_IDLE;
      op_q    <= MD_MULT;
      cnt_q   <= '0;
      rem_q   <= '0;
      quot_q  <= '0;
      dvsr_q  <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      dvsr_q  <= dvsr_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // stall depends on done/ex_hold only through state, so the hazard
  // controller sees no combinational loop.
  assign stall = (state_q == MD_ST_IDLE) ? (start && !flush) : 1'b1;
  assign done  = (state_q == MD_ST_DONE);
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected HI/LO/latency queued at issue,
// compared when done rises; plus flush, ex_hold and reset scenarios.
module tb_muldiv_unit;
  import cpu_defs::*;

  logic        clk = 1'b0;
  logic        rst, start, flush, ex_hold;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        stall, done;
  logic [31:0] hi, lo;

  always #5 clk = ~clk;

  muldiv_unit #(.DIV_ITERS(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .flush   (flush),
    .ex_hold (ex_hold),
    .stall   (stall),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  exp_t        sb_q[$];
  int          n_total = 0;
  int          n_bad   = 0;
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: plain 64-bit arithmetic, truncating signed division.
  function automatic exp_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    logic signed [63:0] sx, sy, sq, sr;
    logic [63:0] p;
    sx    = {{32{x[31]}}, x};
    sy    = {{32{y[31]}}, y};
    e.lat = 2;
    case (o)
      2'b00: begin
        p = sx * sy;
        e.hi = p[63:32];
        e.lo = p[31:0];
      end
      2'b01: begin
        p = {32'd0, x} * {32'd0, y};
        e.hi = p[63:32];
        e.lo = p[31:0];
      end
      default: begin
        e.lat = 34;
        if (y == 32'd0) begin
          e.hi  = x;
          e.lo  = 32'hFFFF_FFFF;
          e.lat = 1;
        end else if (o == 2'b10) begin
          sq   = sx / sy;
          sr   = sx % sy;
          e.hi = sr[31:0];
          e.lo = sq[31:0];
        end else begin
          e.hi = x % y;
          e.lo = x / y;
        end
      end
    endcase
    return e;
  endfunction

  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input bit push);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    if (push) sb_q.push_back(model(o, x, y));
  endtask

  // Called just after the cycle-0 negedge; returns the cycle in which done rose.
  task automatic wait_done(input string tag, input bit scramble, output int cyc);
    int drops;
    drops = 0;
    cyc   = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (scramble && cyc == 1) begin
        a  = $urandom;
        b  = $urandom;
        op = 2'($urandom);
      end
      if (!done && !stall) drops++;
    end while (!done && cyc < 100);
    check({tag, ".done_seen"}, done, 1);
    check({tag, ".stall_held"}, drops, 0);
  endtask

  task automatic pop_check(input string tag, input int cyc);
    exp_t e;
    e = sb_q.pop_front();
    check({tag, ".hi"}, hi, e.hi);
    check({tag, ".lo"}, lo, e.lo);
    check({tag, ".latency"}, cyc, e.lat);
    last_hi = e.hi;
    last_lo = e.lo;
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y);
    int cyc;
    @(negedge clk);
    issue(o, x, y, 1'b1);
    #1;
    check({tag, ".stall_c0"}, stall, 1);
    wait_done(tag, 1'b1, cyc);
    pop_check(tag, cyc);
    start = 1'b0;
  endtask

  initial begin
    int cyc;
    int saw;
    rst = 1'b1; start = 1'b0; flush = 1'b0; ex_hold = 1'b0;
    op  = 2'b00; a = '0; b = '0;

    repeat (2) @(negedge clk);
    check("rst.done", done, 0);
    check("rst.hi", hi, 0);
    check("rst.lo", lo, 0);
    check("rst.stall", stall, 0);
    start = 1'b1;
    #1;
    check("rst.stall_start", stall, 1);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    run_op("mult",     2'b00, 32'hFFFF_FFFE, 32'd3);
    run_op("multu",    2'b01, 32'hFFFF_FFFE, 32'd3);
    run_op("div_neg",  2'b10, 32'hFFFF_FFF9, 32'd2);
    run_op("divu",     2'b11, 32'd100, 32'd7);
    run_op("div0",     2'b10, 32'h1234, 32'd0);
    run_op("divu0",    2'b11, 32'hDEAD, 32'd0);
    run_op("div_ovf",  2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("divu_big", 2'b11, 32'hFFFF_FFFF, 32'h8000_0001);
    run_op("div_nd",   2'b10, 32'd1000, 32'hFFFF_FFF9);
    for (int i = 0; i < 8; i++) run_op("rand", 2'(i), $urandom, $urandom);

    // Flush in cycle 10 of a DIV: IDLE in cycle 11, no done, HI/LO kept.
    saw = 0;
    @(negedge clk);
    issue(2'b10, 32'd1000, 32'd3, 1'b0);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (done) saw++;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    start = 1'b0;
    #1;
    check("flush.idle_stall", stall, 0);
    check("flush.no_done", saw + int'(done), 0);
    check("flush.hi_kept", hi, last_hi);
    check("flush.lo_kept", lo, last_lo);
    run_op("after_flush", 2'b00, 32'd12345, 32'd678);

    // Flush in IDLE masks the request combinationally and blocks the accept.
    @(negedge clk);
    issue(2'b00, 32'd3, 32'd3, 1'b0);
    flush = 1'b1;
    #1;
    check("flush_idle.stall", stall, 0);
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    #1;
    check("flush_idle.no_accept", stall, 0);
    check("flush_idle.no_done", done, 0);

    // ex_hold for 3 cycles in DONE: done for 4 cycles, then one re-accept.
    @(negedge clk);
    issue(2'b00, 32'd5, 32'd7, 1'b1);
    #1;
    wait_done("hold", 1'b0, cyc);
    pop_check("hold", cyc);
    ex_hold = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check("hold.done_held", done, 1);
      if (i == 3) ex_hold = 1'b0;
    end
    @(negedge clk);
    sb_q.push_back(model(2'b00, 32'd5, 32'd7));
    #1;
    check("hold.released", done, 0);
    check("hold.reaccept_stall", stall, 1);
    wait_done("hold2", 1'b0, cyc);
    pop_check("hold2", cyc);
    start = 1'b0;

    // Reset during MUL.
    @(negedge clk);
    issue(2'b00, 32'd7, 32'd9, 1'b0);
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b0;
    @(negedge clk);
    check("rst_mul.done", done, 0);
    check("rst_mul.hi", hi, 0);
    check("rst_mul.lo", lo, 0);
    check("rst_mul.idle", stall, 0);
    rst = 1'b0;

    run_op("pre_rst_div", 2'b11, 32'd100, 32'd7);

    // Reset during DIV.
    @(negedge clk);
    issue(2'b10, 32'd50, 32'd3, 1'b0);
    repeat (5) @(negedge clk);
    rst   = 1'b1;
    start = 1'b0;
    @(negedge clk);
    check("rst_div.done", done, 0);
    check("rst_div.hi", hi, 0);
    check("rst_div.lo", lo, 0);
    check("rst_div.idle", stall, 0);
    rst = 1'b0;

    run_op("post_rst_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
